// File: rtl/uart_tx_fifo_if.sv
// Producer-side stream bundle for uart_tx_fifo: one character per
// valid/ready handshake.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  // Producer drives data/valid and watches ready.
  modport master (output s_data, output s_valid, input s_ready);
  // Transmitter consumes data/valid and drives ready.
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO and configurable character format
// (5..9 data bits, none/even/odd parity, 1 or 2 stop bits). Frames are sent
// back to back with no idle gap while the FIFO holds characters.
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_tx_fifo_if.slave                      stream,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int TICK_W     = $clog2(BAUD_TICKS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  // Elaboration-time rejection of unsupported configurations.
  if (BAUD_TICKS < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be within 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign full           = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty          = (fifo_count == '0);
  assign stream.s_ready = !full;
  assign push           = stream.s_valid && !full;
  assign head           = mem[rd_ptr];

  // Character storage written on an accepted handshake.
  // NOTE: the storage array is deliberately not reset; the pointers and
  // occupancy count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stream.s_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------- framing FSM
  state_t               state;
  state_t               state_next;
  logic [TICK_W-1:0]    tick_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_bit;
  logic                 line_active;
  logic                 tx_next;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 frame_done;

  assign bit_end    = (tick_cnt == TICK_W'(BAUD_TICKS - 1));
  assign last_data  = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop  = (bit_idx == 4'(STOP_BITS - 1));
  assign frame_done = (state == S_STOP) && bit_end && last_stop;

  // A character leaves the FIFO either from idle or exactly as the final
  // stop bit ends, which is what makes consecutive frames gapless.
  assign pop = !empty && ((state == S_IDLE) || frame_done);

  // Next state and the line level implied by the current state.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    case (state)
      S_IDLE: begin
        if (pop) state_next = S_START;
      end
      S_START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        tx_next = shreg[0];
        if (bit_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_next = parity_bit;
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (frame_done) state_next = pop ? S_START : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, bit timing, the character in flight and the registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      tx          <= 1'b1;
      line_active <= 1'b0;
    end else begin
      state <= state_next;

      if (state == S_IDLE || bit_end) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + TICK_W'(1);

      if (state_next != state) bit_idx <= '0;
      else if (bit_end)        bit_idx <= bit_idx + 4'd1;

      // The frame works from its own copy, so later FIFO traffic cannot
      // disturb the character being shifted out.
      if (pop) begin
        shreg      <= head;
        parity_bit <= (^head) ^ (PARITY == 2);
      end else if (state == S_DATA && bit_end) begin
        shreg <= shreg >> 1;
      end

      tx          <= tx_next;
      line_active <= (state != S_IDLE);
    end
  end

  // line_active covers the last stop bit still on the wire after the FSM
  // has already returned to idle.
  assign busy = line_active || (state != S_IDLE) || !empty;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds a write FIFO, a configurable character format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and back-to-back framing with no idle gap. It sits between the on-chip producer (valid/ready stream) and the board TX pin, so producers can burst characters without waiting per frame.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; BAUD_TICKS = CLOCK_FREQ / BAUD_RATE (integer divide), must be >= 2
DATA_BITS, 8, character width, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entry count, power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_data  in  DATA_BITS  character to send
s_valid  in  1  producer offers s_data
s_ready  out  1  FIFO can accept; equals !full
tx  out  1  serial line, idle high
busy  out  1  FIFO non-empty or frame in progress
fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst=1 at clk edge): tx=1, s_ready=1, busy=0, fifo_count=0, FSM=IDLE, all counters 0. FIFO contents discarded. Reset mid-frame aborts the frame: tx=1 from the next cycle.
- Push: s_valid && s_ready at an edge writes s_data. Pop and push in the same cycle leave fifo_count unchanged. No push when full (s_ready=0). s_data is not sampled when s_valid=0.
- Pop: occurs in an IDLE cycle with the FIFO non-empty, or in the last cycle of the final stop bit with the FIFO non-empty. A word pushed into an empty FIFO is visible the next cycle. Start bit therefore appears 2 cycles after the accepting handshake.
- FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE or START.
  - Each bit lasts exactly BAUD_TICKS cycles; tx is registered.
  - START: tx=0.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: even = XOR of data bits; odd = inverted XOR.
  - STOP: STOP_BITS x BAUD_TICKS cycles of tx=1.
  - STOP -> START directly when a pop occurs, so consecutive frames have zero idle cycles between them.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x BAUD_TICKS cycles.
- Popped character is held in a shift register. FIFO changes during a frame do not affect the frame in flight.
- busy = (FSM != IDLE) || (fifo_count != 0). It deasserts the cycle after the final stop bit when nothing is queued.
- fifo_count saturates by construction at FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- Illegal parameter values are rejected by elaboration-time assertion.

Test Plan:
1. CLOCK_FREQ=1_000_000, BAUD_RATE=250_000 (4 ticks), 8N1. Push 0x35 -> tx = 0,1,0,1,0,1,1,0,0,1, each held 4 cycles; start bit begins 2 cycles after handshake; busy falls 1 cycle after stop.
2. DATA_BITS=7, PARITY=1. Push 0x41 -> parity bit 0. Repeat with PARITY=2 -> parity bit 1. Frame is 10 bits x 4 cycles.
3. FIFO_DEPTH=4, s_valid held with 6 words 0x01..0x06 -> 5 accepted (first pops immediately), s_ready=0 with fifo_count=4, 6th accepted after next pop. All 6 frames are contiguous with no idle cycle between stop and start.
4. STOP_BITS=2, push 0xFF then 0x00 -> 8 cycles of stop high between frames, then the second start bit.
5. Assert rst in the middle of the DATA state with 3 words queued -> next cycle tx=1, fifo_count=0, busy=0, s_ready=1. No further frames.
6. Simultaneous push and pop at end of a stop bit with FIFO at 2 -> fifo_count stays 2. Next frame starts immediately and carries the oldest word.
